pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit: shadow EX/MEM/WB pipeline, load-use and dependency stalls,
// operand forwarding selects, branch flush, saturating event counters.
module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int FWD_EN   = 1,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs1_i,
  input  logic [ADDR_W-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam bit FWD = (FWD_EN != 0);
  localparam bit BR3 = (BR_STAGE == 3);

  if (BR_STAGE != 2 && BR_STAGE != 3) begin : g_bad_br
    $error("pipe_hazard_ctrl: BR_STAGE must be 2 or 3");
  end

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              memread;
  } ent_t;

  ent_t ex_q;
  ent_t mem_q;
  ent_t wb_q;
  ent_t id_ent;

  function automatic logic hit(
    input ent_t              e,
    input logic [ADDR_W-1:0] src,
    input logic              used
  );
    return used & e.valid & e.regwrite &
           (e.rd != '0) & (e.rd == src);
  endfunction

  function automatic logic [1:0] sel(
    input logic h_ex,
    input logic h_mem
  );
    logic [1:0] s;
    s = 2'b00;
    if (h_ex)       s = 2'b10;
    else if (h_mem) s = 2'b01;
    return s;
  endfunction

  logic rs1_ex;
  logic rs2_ex;
  logic rs1_mem;
  logic rs2_mem;
  logic stall_raw;
  logic ex_load;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  assign rs1_ex  = hit(ex_q,  id_rs1_i, id_rs1_used_i);
  assign rs2_ex  = hit(ex_q,  id_rs2_i, id_rs2_used_i);
  assign rs1_mem = hit(mem_q, id_rs1_i, id_rs1_used_i);
  assign rs2_mem = hit(mem_q, id_rs2_i, id_rs2_used_i);

  assign id_ent = '{
    valid:    1'b1,
    rd:       id_rd_i,
    regwrite: id_regwrite_i,
    memread:  id_memread_i
  };

  // WB matches never stall: the register file writes through.
  always_comb begin
    stall_raw = 1'b0;
    if (FWD)
      stall_raw = id_valid_i & ex_q.memread &
                  (rs1_ex | rs2_ex);
    else
      stall_raw = id_valid_i &
                  (rs1_ex | rs2_ex | rs1_mem | rs2_mem);
  end

  assign flush_o = branch_taken_i;
  assign stall_o = stall_raw & ~flush_o;
  assign ex_load = id_valid_i & ~stall_o & ~flush_o;

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (FWD && ex_load) begin
      fwd_a_d = sel(rs1_ex, rs1_mem);
      fwd_b_d = sel(rs2_ex, rs2_mem);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_o     <= 2'b00;
      fwd_b_o     <= 2'b00;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      ex_q    <= ex_load ? id_ent : '0;
      mem_q   <= (BR3 && flush_o) ? '0 : ex_q;
      wb_q    <= mem_q;
      fwd_a_o <= fwd_a_d;
      fwd_b_o <= fwd_b_d;
      if (stall_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_o && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: forwarding/BR=MEM and stall-only/BR=EX instances
// driven by shared stimulus, checked against a queue-based model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic       u1 = 0, u2 = 0, rw = 0, mr = 0, bt = 0;

  logic       a_stall, a_flush, b_stall, b_flush;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [3:0] a_sc, a_fc;
  logic [1:0] b_sc, b_fc;

  pipe_hazard_ctrl #(
    .ADDR_W(5), .FWD_EN(1), .BR_STAGE(3), .CNT_W(4)
  ) u_a (
    .clk_i(clk), .rst_n(rst_n),
    .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr),
    .branch_taken_i(bt),
    .stall_o(a_stall), .flush_o(a_flush),
    .fwd_a_o(a_fa), .fwd_b_o(a_fb),
    .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
  );

  pipe_hazard_ctrl #(
    .ADDR_W(5), .FWD_EN(0), .BR_STAGE(2), .CNT_W(2)
  ) u_b (
    .clk_i(clk), .rst_n(rst_n),
    .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr),
    .branch_taken_i(bt),
    .stall_o(b_stall), .flush_o(b_flush),
    .fwd_a_o(b_fa), .fwd_b_o(b_fb),
    .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
  );

  typedef struct {
    bit v; int rd; bit rw; bit mr;
  } ins_t;

  typedef struct {
    bit st; bit fl; int fa; int fb; int sc; int fc;
  } exp_t;

  exp_t sb[2][$];
  ins_t pl[2][$];
  int   sc_m[2], fc_m[2], fa_m[2], fb_m[2];
  bit   fwd_m[2] = '{1'b1, 1'b0};
  bit   br3_m[2] = '{1'b1, 1'b0};
  int   cmax[2]  = '{15, 3};
  int   tests = 0;
  int   fails = 0;

  logic       nv = 0;
  logic [4:0] nrs1 = 0, nrs2 = 0, nrd = 0;
  logic       nu1 = 0, nu2 = 0, nrw = 0, nmr = 0, nbt = 0;

  function automatic bit hit(ins_t e, int src, bit used);
    return used && e.v && e.rw && e.rd != 0 && e.rd == src;
  endfunction

  function automatic int pick(bit he, bit hm);
    return he ? 2 : (hm ? 1 : 0);
  endfunction

  task automatic model_reset();
    ins_t bub;
    bub = '{0, 0, 0, 0};
    for (int k = 0; k < 2; k++) begin
      pl[k].delete();
      repeat (3) pl[k].push_back(bub);
      sc_m[k] = 0; fc_m[k] = 0;
      fa_m[k] = 0; fb_m[k] = 0;
    end
  endtask

  // Index 0 of each queue is the youngest in-flight instruction (EX).
  task automatic model_cycle(bit in_rst);
    for (int k = 0; k < 2; k++) begin
      ins_t ex, mem, nw;
      bit h1e, h2e, h1m, h2m, st, fl, issue;
      exp_t e;
      ex  = pl[k][0];
      mem = pl[k][1];
      h1e = hit(ex,  rs1, u1);
      h2e = hit(ex,  rs2, u2);
      h1m = hit(mem, rs1, u1);
      h2m = hit(mem, rs2, u2);
      fl  = bt;
      if (fwd_m[k]) st = id_valid && ex.mr && (h1e || h2e);
      else          st = id_valid && (h1e || h2e || h1m || h2m);
      st = st && !fl;
      e = '{st, fl, fa_m[k], fb_m[k], sc_m[k], fc_m[k]};
      sb[k].push_back(e);
      if (!in_rst) begin
        issue = id_valid && !st && !fl;
        fa_m[k] = (issue && fwd_m[k]) ? pick(h1e, h1m) : 0;
        fb_m[k] = (issue && fwd_m[k]) ? pick(h2e, h2m) : 0;
        if (st && sc_m[k] < cmax[k]) sc_m[k]++;
        if (fl && fc_m[k] < cmax[k]) fc_m[k]++;
        if (br3_m[k] && fl) pl[k][0].v = 0;
        nw = issue ? '{1, int'(rd), rw, mr} : '{0, 0, 0, 0};
        pl[k].push_front(nw);
        pl[k].delete(3);
      end
    end
  endtask

  task automatic tick(bit r);
    @(posedge clk);
    #1;
    rst_n = !r;
    if (r) model_reset();
    id_valid = nv; rs1 = nrs1; rs2 = nrs2; rd = nrd;
    u1 = nu1; u2 = nu2; rw = nrw; mr = nmr; bt = nbt;
    model_cycle(r);
  endtask

  task automatic set_ins(bit v, int s1, bit a1, int s2, bit a2,
                         int d, bit w, bit m, bit b);
    nv = v; nrs1 = 5'(s1); nu1 = a1; nrs2 = 5'(s2); nu2 = a2;
    nrd = 5'(d); nrw = w; nmr = m; nbt = b;
  endtask

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb[0].size() > 0) begin
      e = sb[0].pop_front();
      chk("a_stall", int'(a_stall), int'(e.st));
      chk("a_flush", int'(a_flush), int'(e.fl));
      chk("a_fwd_a", int'(a_fa), e.fa);
      chk("a_fwd_b", int'(a_fb), e.fb);
      chk("a_stall_cnt", int'(a_sc), e.sc);
      chk("a_flush_cnt", int'(a_fc), e.fc);
    end
    if (sb[1].size() > 0) begin
      e = sb[1].pop_front();
      chk("b_stall", int'(b_stall), int'(e.st));
      chk("b_flush", int'(b_flush), int'(e.fl));
      chk("b_fwd_a", int'(b_fa), e.fa);
      chk("b_fwd_b", int'(b_fb), e.fb);
      chk("b_stall_cnt", int'(b_sc), e.sc);
      chk("b_flush_cnt", int'(b_fc), e.fc);
    end
  end

  initial begin
    model_reset();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick(1);
    // load-use on x5
    set_ins(1, 0, 0, 0, 0, 5, 1, 1, 0); tick(0);
    set_ins(1, 5, 1, 0, 0, 6, 1, 0, 0); repeat (3) tick(0);
    // ALU producer x3 consumed through rs2
    set_ins(1, 0, 0, 0, 0, 3, 1, 0, 0); tick(0);
    set_ins(1, 0, 0, 3, 1, 7, 1, 0, 0); repeat (3) tick(0);
    // branch taken together with a load-use
    set_ins(1, 0, 0, 0, 0, 5, 1, 1, 0); tick(0);
    set_ins(1, 5, 1, 0, 0, 8, 1, 0, 1); tick(0);
    set_ins(1, 5, 1, 0, 0, 8, 1, 0, 0); repeat (2) tick(0);
    // writer of x0 then reader of x0
    set_ins(1, 0, 0, 0, 0, 0, 1, 1, 0); tick(0);
    set_ins(1, 0, 1, 0, 1, 9, 1, 0, 0); repeat (2) tick(0);
    // reset in the middle of a stall
    set_ins(1, 0, 0, 0, 0, 4, 1, 1, 0); tick(0);
    set_ins(1, 4, 1, 0, 0, 10, 1, 0, 0); tick(0);
    tick(1);
    repeat (2) tick(0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        set_ins($urandom_range(0, 99) < 85,
                $urandom_range(0, 3), $urandom_range(0, 9) < 8,
                $urandom_range(0, 3), $urandom_range(0, 9) < 8,
                $urandom_range(0, 3), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, 0);
      end
      nbt = ($urandom_range(0, 99) < 8);
      tick(i == 1500 || i == 1501);
    end
    repeat (2) @(posedge clk);
    chk("sb_drain", sb[0].size() + sb[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
